alu_sequencer: RTL and testbench

Command-driven front end for the team's 16-bit, 8-operation ALU. It accepts ALU commands over a valid/ready interface and reads operands from a 4-entry register file. It drives the combinational ALU core, writes the result back, and returns the result with flags over a second valid/ready interface. It sits between a command source (testbench, controller FSM or host interface) and the ALU datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu16_core.sv | 58 +++++
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU sequencer slice.
// Opcode encoding and FSM state encoding live here.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_INC = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu16_core.sv
// alu16_core: combinational 8-operation ALU.
// Produces the truncated result and a per-op carry/borrow/shift-out bit.
module alu16_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] wide;

    always_comb begin
        wide  = '0;
        y     = '0;
        carry = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            (op == OP_SUB): begin
                // top bit of the extended difference is the borrow
                wide  = {1'b0, a} - {1'b0, b};
                y     = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            (op == OP_AND): y = a & b;
            (op == OP_XOR): y = a ^ b;
            (op == OP_OR):  y = a | b;
            (op == OP_INC): begin
                wide  = {1'b0, a} + ONE;
                y     = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            (op == OP_SHL): begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            (op == OP_SHR): begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command front end for alu16_core.
// Owns the register file, the IDLE/EXEC/RESP FSM and the result registers.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREGS = DEF_NREGS,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_load,
    input  logic             cmd_imm_en,
    input  logic [RW-1:0]    cmd_dst,
    input  logic [RW-1:0]    cmd_srca,
    input  logic [RW-1:0]    cmd_srcb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [RW-1:0]    res_dst,
    output logic             res_zero,
    output logic             res_carry
);

    state_t           state;
    logic [WIDTH-1:0] rf [NREGS];

    logic [2:0]       op_q;
    logic             load_q;
    logic [RW-1:0]    dst_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;

    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic [WIDTH-1:0] wb_y;
    logic             wb_c;

    alu16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (op_q),
        .a     (opa_q),
        .b     (opb_q),
        .y     (alu_y),
        .carry (alu_c)
    );

    // a load bypasses the ALU: the immediate sits in opb_q
    always_comb begin
        wb_y = alu_y;
        wb_c = alu_c;
        if (load_q) begin
            wb_y = opb_q;
            wb_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_dst   <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            op_q      <= OP_ADD;
            load_q    <= 1'b0;
            dst_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        load_q    <= cmd_load;
                        dst_q     <= cmd_dst;
                        opa_q     <= rf[cmd_srca];
                        opb_q     <= (cmd_load || cmd_imm_en)
                                   ? cmd_imm : rf[cmd_srcb];
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rf[dst_q] <= wb_y;
                    res_data  <= wb_y;
                    res_dst   <= dst_q;
                    res_zero  <= (wb_y == '0);
                    res_carry <= wb_c;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer.
// Expected results are queued at command accept and popped on res handshake.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic        cmd_load = 1'b0;
    logic        cmd_imm_en = 1'b0;
    logic [1:0]  cmd_dst = '0;
    logic [1:0]  cmd_srca = '0;
    logic [1:0]  cmd_srcb = '0;
    logic [15:0] cmd_imm = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [1:0]  res_dst;
    logic        res_zero;
    logic        res_carry;

    always #5 clk = ~clk;

    alu_sequencer #(
        .WIDTH (16),
        .NREGS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_load   (cmd_load),
        .cmd_imm_en (cmd_imm_en),
        .cmd_dst    (cmd_dst),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_imm    (cmd_imm),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_dst    (res_dst),
        .res_zero   (res_zero),
        .res_carry  (res_carry)
    );

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic [1:0]  dst;
        logic        zero;
        logic        carry;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rf [4];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a ^ b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a} + 17'd1;
            3'd6:    return {a[15], a[14:0], 1'b0};
            3'd7:    return {a[0], 1'b0, a[15:1]};
            default: return '0;
        endcase
    endfunction

    // scoreboard pop on every result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_res", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".data"},  res_data,  e.data);
                chk({e.tag, ".dst"},   res_dst,   e.dst);
                chk({e.tag, ".zero"},  res_zero,  e.zero);
                chk({e.tag, ".carry"}, res_carry, e.carry);
            end
        end
    end

    task automatic issue(input string tag, input bit load,
                         input logic [2:0] op, input bit imm_en,
                         input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sbi, input logic [15:0] imm,
                         input bit full, output int waits);
        exp_t        e;
        logic [16:0] r;
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        cmd_load   = load;
        cmd_op     = op;
        cmd_imm_en = imm_en;
        cmd_dst    = dst;
        cmd_srca   = sa;
        cmd_srcb   = sbi;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        a = m_rf[sa];
        b = imm_en ? imm : m_rf[sbi];
        r = load ? {1'b0, imm} : ref_alu(op, a, b);
        e = '{tag, r[15:0], dst, (r[15:0] == 16'h0), r[16]};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sb.push_back(e);
        m_rf[dst] = r[15:0];
        if (full) begin
            @(negedge clk);
            chk({tag, ".exec_valid"}, res_valid, 32'd0);
            chk({tag, ".exec_ready"}, cmd_ready, 32'd0);
            @(negedge clk);
            chk({tag, ".resp_valid"}, res_valid, 32'd1);
            if (res_ready) begin
                @(negedge clk);
                chk({tag, ".ready_back"}, cmd_ready, 32'd1);
                chk({tag, ".valid_drop"}, res_valid, 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [15:0] d0;
        logic [1:0]  t0;
        logic        z0;
        logic        c0;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst.cmd_ready", cmd_ready, 32'd1);
        chk("rst.res_valid", res_valid, 32'd0);
        chk("rst.res_data",  res_data,  32'd0);
        chk("rst.res_dst",   res_dst,   32'd0);
        chk("rst.res_zero",  res_zero,  32'd0);
        chk("rst.res_carry", res_carry, 32'd0);
        rst_n = 1'b1;

        issue("ld_r0",  1, OP_ADD, 0, 0, 0, 0, 16'h7FFF, 1, w);
        issue("inc_r0", 0, OP_INC, 0, 1, 0, 0, 16'h0,    1, w);

        issue("ld_r1",  1, OP_ADD, 0, 1, 0, 0, 16'hFFFF, 1, w);
        issue("ld_r2",  1, OP_ADD, 0, 2, 0, 0, 16'h0001, 1, w);
        issue("add",    0, OP_ADD, 0, 0, 1, 2, 16'h0,    1, w);
        issue("sub21",  0, OP_SUB, 0, 0, 2, 1, 16'h0,    1, w);
        issue("sub12",  0, OP_SUB, 0, 0, 1, 2, 16'h0,    1, w);

        issue("ld_r3",  1, OP_ADD, 0, 3, 0, 0, 16'h8001, 1, w);
        issue("shl",    0, OP_SHL, 0, 0, 3, 0, 16'h0,    1, w);
        issue("shr",    0, OP_SHR, 0, 0, 3, 0, 16'h0,    1, w);
        issue("andi",   0, OP_AND, 1, 0, 3, 0, 16'h00FF, 1, w);
        issue("xori",   0, OP_XOR, 1, 0, 3, 0, 16'h8001, 1, w);
        issue("ori",    0, OP_OR,  1, 0, 3, 0, 16'h0F00, 1, w);
        issue("inc_ff", 0, OP_INC, 0, 0, 1, 0, 16'h0,    1, w);

        // result held back while another command waits
        res_ready = 1'b0;
        issue("bp", 0, OP_ADD, 0, 0, 3, 2, 16'h0, 1, w);
        d0 = res_data;
        t0 = res_dst;
        z0 = res_zero;
        c0 = res_carry;
        cmd_op    = OP_SUB;
        cmd_load  = 1'b0;
        cmd_dst   = 2'd0;
        cmd_srca  = 2'd1;
        cmd_srcb  = 2'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.valid", res_valid, 32'd1);
            chk("bp.cmd_ready", cmd_ready, 32'd0);
            chk("bp.data_hold", res_data, d0);
            chk("bp.dst_hold", res_dst, t0);
            chk("bp.flag_hold", {res_zero, res_carry}, {z0, c0});
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        issue("bp_next", 0, OP_SUB, 0, 0, 1, 2, 16'h0, 1, w);
        chk("bp.accept_wait", w, 32'd1);

        issue("ld5",    1, OP_ADD, 0, 0, 0, 0, 16'h0005, 1, w);
        issue("alias",  0, OP_ADD, 0, 0, 0, 0, 16'h0,    1, w);
        issue("alias2", 0, OP_INC, 0, 0, 0, 0, 16'h0,    1, w);

        // reset lands while the load is in EXEC
        issue("rst_ld", 1, OP_ADD, 0, 2, 0, 0, 16'h1234, 0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.res_valid", res_valid, 32'd0);
        chk("midrst.cmd_ready", cmd_ready, 32'd1);
        chk("midrst.res_data",  res_data,  32'd0);
        sb.delete();
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.ready_rel", cmd_ready, 32'd1);
        for (int k = 0; k < 4; k++) begin
            issue($sformatf("rd%0d", k), 0, OP_OR, 1, 2'(k), 2'(k), 2'(k),
                  16'h0, 1, w);
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
